instr_stream_encoder: RTL and testbench

- Encoder counterpart of the pipelined instruction decoder.
- Accepts symbolic instructions (mnemonic index plus register and immediate fields) over a valid/ready handshake.
- Packs each into the 16-bit ISA word, buffers the words in a small FIFO and writes them sequentially into instruction memory.
- Used by the program loader/self-test path to build programs in IMEM before the core is released.

---
 rtl/instr_stream_encoder_if.sv | 47 ++++
 rtl/instr_stream_encoder.sv | 175 +++++++++++++++++
 tb/tb_instr_stream_encoder.sv | 436 ++++++++++++++++++++++++++++++++++++++++
 3 files changed

// File: rtl/instr_stream_encoder_if.sv
// ----------------------------------------------------------------------------
// instr_stream_encoder_if
// Bus bundle for the instruction stream encoder. It carries the symbolic
// instruction input channel and the instruction-memory write channel.
//
// Handshake semantics (both channels):
//   A transfer happens on a rising clk edge where the source's valid
//   (in_valid / imem_we) and the sink's ready (in_ready / imem_ready) are both
//   1. The source holds valid and its payload stable until that transfer
//   happens. Ready may change freely and is never a function of a future
//   transfer.
//
// Signals:
//   in_valid, in_op[4:0], in_rd/in_rs/in_rt[2:0], in_imm[12:0] : producer -> encoder
//   in_ready                                                     : encoder -> producer
//   imem_we, imem_addr[ADDR_W-1:0], imem_wdata[15:0]             : encoder -> IMEM
//   imem_ready                                                   : IMEM -> encoder
//
// Modports:
//   slave  : encoder view
//   master : environment view (instruction producer plus IMEM)
// ----------------------------------------------------------------------------
interface instr_stream_encoder_if #(
  parameter int ADDR_W = 8
);
  logic              in_valid;
  logic              in_ready;
  logic [4:0]        in_op;
  logic [2:0]        in_rd;
  logic [2:0]        in_rs;
  logic [2:0]        in_rt;
  logic [12:0]       in_imm;
  logic              imem_we;
  logic              imem_ready;
  logic [ADDR_W-1:0] imem_addr;
  logic [15:0]       imem_wdata;

  modport slave (
    input  in_valid, in_op, in_rd, in_rs, in_rt, in_imm, imem_ready,
    output in_ready, imem_we, imem_addr, imem_wdata
  );

  modport master (
    output in_valid, in_op, in_rd, in_rs, in_rt, in_imm, imem_ready,
    input  in_ready, imem_we, imem_addr, imem_wdata
  );
endinterface

// File: rtl/instr_stream_encoder.sv
// ----------------------------------------------------------------------------
// instr_stream_encoder
// Packs symbolic instructions into 16-bit ISA words and writes them to
// consecutive instruction-memory addresses through a small word FIFO. A
// program starts with load_start and ends once STP has been written.
//
// Ports:
//   clk, rst      : clock, asynchronous active-high reset
//   load_start    : start a new program at start_addr (honoured in IDLE/DONE)
//   start_addr    : first IMEM address of the program
//   bus           : instr_stream_encoder_if.slave (instruction in, IMEM out)
//   prog_done     : STP written and FIFO drained; held until next load_start
//   err_illegal   : sticky, an illegal in_op was consumed
//   err_range     : sticky, an immediate did not fit its field
//   state_dbg     : current FSM state (0 IDLE, 1 RUN, 2 DRAIN, 3 DONE)
//
// Build option ENC_WRAP_GUARD_EN: the write pointer saturates at the top
// address; later words are drained without being written and set err_range.
// Without it the pointer wraps silently to 0.
// ----------------------------------------------------------------------------
module instr_stream_encoder #(
  parameter int ADDR_W     = 8,
  parameter int FIFO_DEPTH = 4
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  load_start,
  input  logic [ADDR_W-1:0]     start_addr,
  instr_stream_encoder_if.slave bus,
  output logic                  prog_done,
  output logic                  err_illegal,
  output logic                  err_range,
  output logic [1:0]            state_dbg
);
  localparam int IDX_W = $clog2(FIFO_DEPTH);
  localparam int CNT_W = IDX_W + 1;
  localparam logic [4:0] OP_STP = 5'd11;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    RUN   = 2'd1,
    DRAIN = 2'd2,
    DONE  = 2'd3
  } state_t;

  state_t            state, state_nx;
  logic [15:0]       mem [FIFO_DEPTH];
  logic [IDX_W-1:0]  wr_idx, rd_idx;
  logic [CNT_W-1:0]  count;
  logic [ADDR_W-1:0] ptr, ptr_nx;
  logic              fifo_full, fifo_empty;
  logic [15:0]       enc_word;
  logic              enc_legal, enc_over;
  logic              start_ok, accept, push, pop, wr_fire, discard, sat;

  // Combinational packing of the presented instruction.
  always_comb begin
    enc_word  = 16'h0000;
    enc_legal = 1'b1;
    enc_over  = 1'b0;
    case (bus.in_op)
      5'd0, 5'd1, 5'd2, 5'd3, 5'd4, 5'd5, 5'd6, 5'd7:
        enc_word = {4'b0000, bus.in_op[2:0], bus.in_rd, bus.in_rs, bus.in_rt};
      5'd8: begin
        enc_word = {6'b000100, bus.in_rd, bus.in_imm[6:0]};
        enc_over = |bus.in_imm[12:7];
      end
      5'd9: begin
        enc_word = {6'b000101, bus.in_rd, bus.in_imm[6:0]};
        enc_over = |bus.in_imm[12:7];
      end
      5'd10: begin
        enc_word = {6'b000110, bus.in_rd, bus.in_imm[6:0]};
        enc_over = |bus.in_imm[12:7];
      end
      5'd11: enc_word = 16'h1C00;
      5'd12: begin
        enc_word = {3'b010, bus.in_rd, bus.in_imm[9:0]};
        enc_over = |bus.in_imm[12:10];
      end
      5'd13: begin
        enc_word = {3'b011, bus.in_rd, bus.in_imm[9:0]};
        enc_over = |bus.in_imm[12:10];
      end
      5'd14: enc_word = {3'b100, bus.in_imm};
      5'd15: enc_word = {3'b101, bus.in_imm};
      5'd16: enc_word = {3'b110, bus.in_imm};
      5'd17: enc_word = {3'b111, 13'd0};   // JR target always zero
      default: enc_legal = 1'b0;
    endcase
  end

  assign fifo_full    = (count == CNT_W'(FIFO_DEPTH));
  assign fifo_empty   = (count == '0);
  assign start_ok     = load_start && ((state == IDLE) || (state == DONE));
  assign bus.in_ready = (state == RUN) && !fifo_full;
  assign accept       = bus.in_valid && bus.in_ready;
  // Illegal ops complete the handshake but never enter the FIFO.
  assign push         = accept && enc_legal;

  // Once saturated, words still leave the FIFO (so STP completes) but are
  // never presented to IMEM.
  assign bus.imem_we    = !fifo_empty && !sat;
  assign wr_fire        = bus.imem_we && bus.imem_ready;
  assign discard        = !fifo_empty && sat;
  assign pop            = wr_fire || discard;
  assign bus.imem_addr  = ptr;
  assign bus.imem_wdata = fifo_empty ? 16'h0000 : mem[rd_idx];

  assign prog_done = (state == DONE);
  assign state_dbg = state;

`ifdef ENC_WRAP_GUARD_EN
  assign ptr_nx = (ptr == '1) ? ptr : ptr + ADDR_W'(1);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      sat <= 1'b0;
    end else if (start_ok) begin
      sat <= 1'b0;
    end else if (wr_fire && (ptr == '1)) begin
      sat <= 1'b1;
    end
  end
`else
  assign ptr_nx = ptr + ADDR_W'(1);
  assign sat    = 1'b0;
`endif

  always_comb begin
    state_nx = state;
    case (state)
      IDLE:    if (load_start) state_nx = RUN;
      RUN:     if (accept && (bus.in_op == OP_STP)) state_nx = DRAIN;
      DRAIN:   if (fifo_empty) state_nx = DONE;
      DONE:    if (load_start) state_nx = RUN;
      default: state_nx = IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state       <= IDLE;
      wr_idx      <= '0;
      rd_idx      <= '0;
      count       <= '0;
      ptr         <= '0;
      err_illegal <= 1'b0;
      err_range   <= 1'b0;
    end else begin
      state <= state_nx;
      if (push) wr_idx <= wr_idx + IDX_W'(1);
      if (pop)  rd_idx <= rd_idx + IDX_W'(1);
      case ({push, pop})
        2'b10:   count <= count + CNT_W'(1);
        2'b01:   count <= count - CNT_W'(1);
        default: count <= count;
      endcase
      if (start_ok) begin
        ptr         <= start_addr;
        err_illegal <= 1'b0;
        err_range   <= 1'b0;
      end else begin
        if (wr_fire) ptr <= ptr_nx;
        if (accept && !enc_legal) err_illegal <= 1'b1;
        if ((push && enc_over) || discard) err_range <= 1'b1;
      end
    end
  end

  // Storage needs no reset: the read port is masked while the FIFO is empty.
  always_ff @(posedge clk) begin
    if (push) mem[wr_idx] <= enc_word;
  end
endmodule

// File: tb/tb_instr_stream_encoder.sv
// ----------------------------------------------------------------------------
// tb_instr_stream_encoder
// Directed self-checking bench for instr_stream_encoder. Inputs change 1 time
// unit after the rising edge; outputs are observed on the falling edge.
// A monitor records every IMEM write; each test compares that record against
// hand-computed expected words and addresses.
// ----------------------------------------------------------------------------
module tb_instr_stream_encoder;
  localparam int ADDR_W = 8;

  logic              clk;
  logic              rst;
  logic              load_start;
  logic [ADDR_W-1:0] start_addr;
  logic              prog_done;
  logic              err_illegal;
  logic              err_range;
  logic [1:0]        state_dbg;

  instr_stream_encoder_if #(.ADDR_W(ADDR_W)) bus ();

  instr_stream_encoder #(.ADDR_W(ADDR_W), .FIFO_DEPTH(4)) dut (
    .clk        (clk),
    .rst        (rst),
    .load_start (load_start),
    .start_addr (start_addr),
    .bus        (bus),
    .prog_done  (prog_done),
    .err_illegal(err_illegal),
    .err_range  (err_range),
    .state_dbg  (state_dbg)
  );

  int tests = 0;
  int fails = 0;

  logic [15:0]       exp_q[$];
  logic [ADDR_W-1:0] exp_a[$];
  logic [15:0]       got_q[$];
  logic [ADDR_W-1:0] got_a[$];

  // Clock / reset
  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  // Write monitor
  always @(negedge clk) begin
    if (rst === 1'b0 && bus.imem_we === 1'b1 && bus.imem_ready === 1'b1) begin
      got_q.push_back(bus.imem_wdata);
      got_a.push_back(bus.imem_addr);
    end
  end

  // Driver tasks
  task automatic clear_sb();
    exp_q.delete(); exp_a.delete(); got_q.delete(); got_a.delete();
  endtask

  task automatic expect_word(input logic [15:0] d, input logic [ADDR_W-1:0] a);
    exp_q.push_back(d);
    exp_a.push_back(a);
  endtask

  task automatic start_prog(input logic [ADDR_W-1:0] a);
    load_start = 1'b1;
    start_addr = a;
    @(posedge clk); #1;
    load_start = 1'b0;
  endtask

  task automatic send_instr(input logic [4:0] op, input logic [2:0] rd,
                            input logic [2:0] rs, input logic [2:0] rt,
                            input logic [12:0] imm);
    bit done = 1'b0;
    int n = 0;
    bus.in_valid = 1'b1;
    bus.in_op = op; bus.in_rd = rd; bus.in_rs = rs; bus.in_rt = rt; bus.in_imm = imm;
    while (!done && n < 200) begin
      @(negedge clk);
      if (bus.in_ready === 1'b1) done = 1'b1;
      @(posedge clk); #1;
      n++;
    end
    bus.in_valid = 1'b0;
    tests++;
    if (!done) begin
      fails++;
      $display("FAIL send_timeout: op %0d not accepted, in_ready=%b required 1", op, bus.in_ready);
    end
  endtask

  task automatic wait_done(output bit ok);
    ok = 1'b0;
    for (int i = 0; i < 100 && !ok; i++) begin
      @(negedge clk);
      if (prog_done === 1'b1) ok = 1'b1;
    end
    @(posedge clk); #1;
  endtask

  // Tests
  task automatic test_reset();
    @(negedge clk);
    tests++;
    if (bus.in_ready !== 1'b0 || bus.imem_we !== 1'b0 || prog_done !== 1'b0 ||
        err_illegal !== 1'b0 || err_range !== 1'b0) begin
      fails++;
      $display("FAIL reset_ctrl: rdy=%b we=%b done=%b ill=%b rng=%b, required all 0",
               bus.in_ready, bus.imem_we, prog_done, err_illegal, err_range);
    end
    tests++;
    if (bus.imem_addr !== 8'h00 || bus.imem_wdata !== 16'h0000 || state_dbg !== 2'd0) begin
      fails++;
      $display("FAIL reset_bus: addr=%h data=%h state=%0d, required 00 0000 0",
               bus.imem_addr, bus.imem_wdata, state_dbg);
    end
    @(posedge clk); #1;
    rst = 1'b0;
    @(negedge clk);
    tests++;
    if (bus.in_ready !== 1'b0 || state_dbg !== 2'd0) begin
      fails++;
      $display("FAIL idle_hold: rdy=%b state=%0d, required 0 0", bus.in_ready, state_dbg);
    end
    @(posedge clk); #1;
  endtask

  task automatic test_single_add();
    bit ok;
    clear_sb();
    start_prog(8'h10);
    tests++;
    if (state_dbg !== 2'd1 || bus.in_ready !== 1'b1) begin
      fails++;
      $display("FAIL run_entry: state=%0d rdy=%b, required 1 1", state_dbg, bus.in_ready);
    end
    send_instr(5'd0, 3'd1, 3'd2, 3'd3, 13'd0);
    @(negedge clk);
    tests++;
    if (bus.imem_we !== 1'b1 || bus.imem_addr !== 8'h10 || bus.imem_wdata !== 16'h0053) begin
      fails++;
      $display("FAIL add_latency: we=%b addr=%h data=%h, required 1 10 0053",
               bus.imem_we, bus.imem_addr, bus.imem_wdata);
    end
    @(posedge clk); #1;
    send_instr(5'd11, 3'd0, 3'd0, 3'd0, 13'd0);
    wait_done(ok);
    expect_word(16'h0053, 8'h10);
    expect_word(16'h1C00, 8'h11);
    tests++;
    if (!ok || got_q.size() != exp_q.size()) begin
      fails++;
      $display("FAIL add_count: done=%b words=%0d, required 1 %0d", ok, got_q.size(), exp_q.size());
    end
    foreach (exp_q[i]) if (i < got_q.size()) begin
      tests++;
      if (got_q[i] !== exp_q[i] || got_a[i] !== exp_a[i]) begin
        fails++;
        $display("FAIL add_word%0d: got %h@%h, required %h@%h", i, got_q[i], got_a[i], exp_q[i], exp_a[i]);
      end
    end
  endtask

  task automatic test_program();
    bit ok;
    clear_sb();
    start_prog(8'h20);
    send_instr(5'd10, 3'd2, 3'd0, 3'd0, 13'd5);
    send_instr(5'd13, 3'd1, 3'd0, 3'd0, 13'h03F);
    send_instr(5'd16, 3'd0, 3'd0, 3'd0, 13'h123);
    send_instr(5'd11, 3'd0, 3'd0, 3'd0, 13'd0);
    @(negedge clk);
    tests++;
    if (bus.in_ready !== 1'b0 || state_dbg !== 2'd2) begin
      fails++;
      $display("FAIL stp_drain: rdy=%b state=%0d, required 0 2", bus.in_ready, state_dbg);
    end
    @(posedge clk); #1;
    wait_done(ok);
    @(negedge clk);
    tests++;
    if (!ok || prog_done !== 1'b1 || bus.in_ready !== 1'b0 || bus.imem_we !== 1'b0) begin
      fails++;
      $display("FAIL prog_done: seen=%b done=%b rdy=%b we=%b, required 1 1 0 0",
               ok, prog_done, bus.in_ready, bus.imem_we);
    end
    @(posedge clk); #1;
    expect_word(16'h1905, 8'h20);
    expect_word(16'h643F, 8'h21);
    expect_word(16'hC123, 8'h22);
    expect_word(16'h1C00, 8'h23);
    tests++;
    if (got_q.size() != exp_q.size()) begin
      fails++;
      $display("FAIL prog_count: got %0d words, required %0d", got_q.size(), exp_q.size());
    end
    foreach (exp_q[i]) if (i < got_q.size()) begin
      tests++;
      if (got_q[i] !== exp_q[i] || got_a[i] !== exp_a[i]) begin
        fails++;
        $display("FAIL prog_word%0d: got %h@%h, required %h@%h", i, got_q[i], got_a[i], exp_q[i], exp_a[i]);
      end
    end
  endtask

  task automatic test_backpressure();
    bit ok;
    clear_sb();
    bus.imem_ready = 1'b0;
    start_prog(8'h40);
    send_instr(5'd1, 3'd7, 3'd6, 3'd5, 13'd0);
    send_instr(5'd2, 3'd1, 3'd0, 3'd0, 13'd0);
    send_instr(5'd3, 3'd2, 3'd3, 3'd4, 13'd0);
    send_instr(5'd7, 3'd0, 3'd1, 3'd2, 13'd0);
    // Offer a fifth word while the FIFO is full.
    bus.in_valid = 1'b1;
    bus.in_op = 5'd14; bus.in_imm = 13'h1FFF;
    for (int c = 0; c < 3; c++) begin
      @(negedge clk);
      tests++;
      if (bus.in_ready !== 1'b0 || bus.imem_we !== 1'b1 ||
          bus.imem_addr !== 8'h40 || bus.imem_wdata !== 16'h03F5) begin
        fails++;
        $display("FAIL stall_c%0d: rdy=%b we=%b addr=%h data=%h, required 0 1 40 03F5",
                 c, bus.in_ready, bus.imem_we, bus.imem_addr, bus.imem_wdata);
      end
      @(posedge clk); #1;
    end
    bus.imem_ready = 1'b1;
    send_instr(5'd14, 3'd0, 3'd0, 3'd0, 13'h1FFF);
    send_instr(5'd17, 3'd0, 3'd0, 3'd0, 13'h055);
    send_instr(5'd11, 3'd0, 3'd0, 3'd0, 13'd0);
    wait_done(ok);
    expect_word(16'h03F5, 8'h40);
    expect_word(16'h0440, 8'h41);
    expect_word(16'h069C, 8'h42);
    expect_word(16'h0E0A, 8'h43);
    expect_word(16'h9FFF, 8'h44);
    expect_word(16'hE000, 8'h45);
    expect_word(16'h1C00, 8'h46);
    tests++;
    if (!ok || got_q.size() != exp_q.size()) begin
      fails++;
      $display("FAIL bp_count: done=%b words=%0d, required 1 %0d", ok, got_q.size(), exp_q.size());
    end
    foreach (exp_q[i]) if (i < got_q.size()) begin
      tests++;
      if (got_q[i] !== exp_q[i] || got_a[i] !== exp_a[i]) begin
        fails++;
        $display("FAIL bp_word%0d: got %h@%h, required %h@%h", i, got_q[i], got_a[i], exp_q[i], exp_a[i]);
      end
    end
  endtask

  task automatic test_errors();
    bit ok;
    clear_sb();
    start_prog(8'h60);
    send_instr(5'd8, 3'd0, 3'd0, 3'd0, 13'd200);
    send_instr(5'd25, 3'd1, 3'd1, 3'd1, 13'd1);
    send_instr(5'd18, 3'd2, 3'd2, 3'd2, 13'd2);
    send_instr(5'd11, 3'd0, 3'd0, 3'd0, 13'd0);
    wait_done(ok);
    tests++;
    if (!ok || err_range !== 1'b1 || err_illegal !== 1'b1) begin
      fails++;
      $display("FAIL err_flags: done=%b rng=%b ill=%b, required 1 1 1", ok, err_range, err_illegal);
    end
    expect_word(16'h1048, 8'h60);
    expect_word(16'h1C00, 8'h61);
    tests++;
    if (got_q.size() != exp_q.size()) begin
      fails++;
      $display("FAIL err_count: got %0d words, required %0d", got_q.size(), exp_q.size());
    end
    foreach (exp_q[i]) if (i < got_q.size()) begin
      tests++;
      if (got_q[i] !== exp_q[i] || got_a[i] !== exp_a[i]) begin
        fails++;
        $display("FAIL err_word%0d: got %h@%h, required %h@%h", i, got_q[i], got_a[i], exp_q[i], exp_a[i]);
      end
    end
    clear_sb();
    start_prog(8'h70);
    tests++;
    if (err_range !== 1'b0 || err_illegal !== 1'b0 || prog_done !== 1'b0) begin
      fails++;
      $display("FAIL err_clear: rng=%b ill=%b done=%b, required 0 0 0", err_range, err_illegal, prog_done);
    end
    send_instr(5'd11, 3'd0, 3'd0, 3'd0, 13'd0);
    wait_done(ok);
    tests++;
    if (!ok || got_q.size() != 1 || got_q[0] !== 16'h1C00 || got_a[0] !== 8'h70) begin
      fails++;
      $display("FAIL restart_stp: done=%b words=%0d, required 1 word 1C00@70", ok, got_q.size());
    end
  endtask

  task automatic test_boundary();
    bit ok;
    clear_sb();
    start_prog(8'h80);
    send_instr(5'd9, 3'd5, 3'd0, 3'd0, 13'd127);
    send_instr(5'd12, 3'd3, 3'd0, 3'd0, 13'd1023);
    send_instr(5'd17, 3'd0, 3'd0, 3'd0, 13'h055);
    send_instr(5'd11, 3'd0, 3'd0, 3'd0, 13'd0);
    wait_done(ok);
    tests++;
    if (!ok || err_range !== 1'b0 || err_illegal !== 1'b0) begin
      fails++;
      $display("FAIL bound_flags: done=%b rng=%b ill=%b, required 1 0 0", ok, err_range, err_illegal);
    end
    expect_word(16'h16FF, 8'h80);
    expect_word(16'h4FFF, 8'h81);
    expect_word(16'hE000, 8'h82);
    expect_word(16'h1C00, 8'h83);
    tests++;
    if (got_q.size() != exp_q.size()) begin
      fails++;
      $display("FAIL bound_count: got %0d words, required %0d", got_q.size(), exp_q.size());
    end
    foreach (exp_q[i]) if (i < got_q.size()) begin
      tests++;
      if (got_q[i] !== exp_q[i] || got_a[i] !== exp_a[i]) begin
        fails++;
        $display("FAIL bound_word%0d: got %h@%h, required %h@%h", i, got_q[i], got_a[i], exp_q[i], exp_a[i]);
      end
    end
  endtask

  task automatic test_wrap();
    bit ok;
    logic exp_rng;
    clear_sb();
    start_prog(8'hFE);
    send_instr(5'd2, 3'd1, 3'd0, 3'd0, 13'd0);
    send_instr(5'd3, 3'd2, 3'd3, 3'd4, 13'd0);
    send_instr(5'd7, 3'd0, 3'd1, 3'd2, 13'd0);
    send_instr(5'd11, 3'd0, 3'd0, 3'd0, 13'd0);
    wait_done(ok);
    expect_word(16'h0440, 8'hFE);
    expect_word(16'h069C, 8'hFF);
`ifdef ENC_WRAP_GUARD_EN
    exp_rng = 1'b1;
`else
    exp_rng = 1'b0;
    expect_word(16'h0E0A, 8'h00);
    expect_word(16'h1C00, 8'h01);
`endif
    tests++;
    if (!ok || err_range !== exp_rng) begin
      fails++;
      $display("FAIL wrap_flags: done=%b rng=%b, required 1 %b", ok, err_range, exp_rng);
    end
    tests++;
    if (got_q.size() != exp_q.size()) begin
      fails++;
      $display("FAIL wrap_count: got %0d words, required %0d", got_q.size(), exp_q.size());
    end
    foreach (exp_q[i]) if (i < got_q.size()) begin
      tests++;
      if (got_q[i] !== exp_q[i] || got_a[i] !== exp_a[i]) begin
        fails++;
        $display("FAIL wrap_word%0d: got %h@%h, required %h@%h", i, got_q[i], got_a[i], exp_q[i], exp_a[i]);
      end
    end
  endtask

  task automatic test_reset_mid();
    bit ok;
    clear_sb();
    start_prog(8'h90);
    send_instr(5'd25, 3'd0, 3'd0, 3'd0, 13'd0);
    bus.imem_ready = 1'b0;
    send_instr(5'd1, 3'd7, 3'd6, 3'd5, 13'd0);
    send_instr(5'd2, 3'd1, 3'd0, 3'd0, 13'd0);
    rst = 1'b1;
    #1;
    tests++;
    if (bus.in_ready !== 1'b0 || bus.imem_we !== 1'b0 || prog_done !== 1'b0 ||
        err_illegal !== 1'b0 || err_range !== 1'b0 || state_dbg !== 2'd0) begin
      fails++;
      $display("FAIL midrst_ctrl: rdy=%b we=%b done=%b ill=%b rng=%b state=%0d, required all 0",
               bus.in_ready, bus.imem_we, prog_done, err_illegal, err_range, state_dbg);
    end
    tests++;
    if (bus.imem_addr !== 8'h00 || bus.imem_wdata !== 16'h0000) begin
      fails++;
      $display("FAIL midrst_bus: addr=%h data=%h, required 00 0000", bus.imem_addr, bus.imem_wdata);
    end
    @(posedge clk); #1;
    rst = 1'b0;
    bus.imem_ready = 1'b1;
    repeat (5) @(negedge clk);
    tests++;
    if (got_q.size() != 0 || bus.imem_we !== 1'b0 || bus.in_ready !== 1'b0) begin
      fails++;
      $display("FAIL midrst_quiet: words=%0d we=%b rdy=%b, required 0 0 0",
               got_q.size(), bus.imem_we, bus.in_ready);
    end
    @(posedge clk); #1;
    start_prog(8'hA0);
    send_instr(5'd11, 3'd0, 3'd0, 3'd0, 13'd0);
    wait_done(ok);
    tests++;
    if (!ok || got_q.size() != 1 || got_q[0] !== 16'h1C00 || got_a[0] !== 8'hA0) begin
      fails++;
      $display("FAIL midrst_restart: done=%b words=%0d, required 1 word 1C00@A0", ok, got_q.size());
    end
  endtask

  initial begin
    rst = 1'b1;
    load_start = 1'b0;
    start_addr = '0;
    bus.in_valid = 1'b0;
    bus.in_op = '0; bus.in_rd = '0; bus.in_rs = '0; bus.in_rt = '0; bus.in_imm = '0;
    bus.imem_ready = 1'b1;
    test_reset();
    test_single_add();
    test_program();
    test_backpressure();
    test_errors();
    test_boundary();
    test_wrap();
    test_reset_mid();
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end
endmodule
